// File: rtl/scope_capture_pkg.sv
// ---------------------------------------------------------------------------
// scope_pkg
// Shared definitions for the triggered scope capture stage: sample width,
// capture FSM state encoding, trigger mode encodings and the trigger
// detection helper used by the top level.
// ---------------------------------------------------------------------------
package scope_pkg;

    localparam int SAMPLE_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

    localparam logic [1:0] TRIG_RISE = 2'b00;
    localparam logic [1:0] TRIG_FALL = 2'b01;
    localparam logic [1:0] TRIG_FREE = 2'b10;

    // Level-crossing test on one sample strobe. Mode 2'b11 is not a named
    // encoding and falls through to rising-edge behaviour.
    function automatic logic trig_edge(
        input logic [1:0]          mode,
        input logic                prev_valid,
        input logic [SAMPLE_W-1:0] prev,
        input logic [SAMPLE_W-1:0] cur,
        input logic [SAMPLE_W-1:0] level
    );
        logic hit;
        hit = 1'b0;
        case (mode)
            TRIG_FREE: hit = 1'b1;
            TRIG_FALL: hit = prev_valid && (prev >= level) && (cur < level);
            TRIG_RISE: hit = prev_valid && (prev < level) && (cur >= level);
            default:   hit = prev_valid && (prev < level) && (cur >= level);
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/scope_capture_if.sv
// ---------------------------------------------------------------------------
// scope_capture_if
// Software-facing bus of the scope capture stage (Nios II side).
//   arm           master->slave  one-cycle capture start pulse
//   trig_level    master->slave  trigger threshold
//   trig_mode     master->slave  trigger mode
//   rd_addr       master->slave  buffer read address (0 = trigger sample)
//   rd_signal     slave->master  registered signal read data
//   rd_modulation slave->master  registered modulation read data
//   busy          slave->master  capture armed or in progress
//   done          slave->master  record complete
//   auto_trig     slave->master  record was started by the timeout
// ---------------------------------------------------------------------------
interface scope_capture_if #(
    parameter int ADDR_W = 8
);
    import scope_pkg::*;

    logic                arm;
    logic [SAMPLE_W-1:0] trig_level;
    logic [1:0]          trig_mode;
    logic [ADDR_W-1:0]   rd_addr;
    logic [SAMPLE_W-1:0] rd_signal;
    logic [SAMPLE_W-1:0] rd_modulation;
    logic                busy;
    logic                done;
    logic                auto_trig;

    modport master (
        output arm, trig_level, trig_mode, rd_addr,
        input  rd_signal, rd_modulation, busy, done, auto_trig
    );

    modport slave (
        input  arm, trig_level, trig_mode, rd_addr,
        output rd_signal, rd_modulation, busy, done, auto_trig
    );

endinterface

// File: rtl/scope_capture_ram.sv
// ---------------------------------------------------------------------------
// capture_ram
// Simple dual-port record buffer: one write port, one registered read port.
// Read of an address being written in the same cycle returns the old word.
//   clk      system clock
//   rst_n    synchronous active-low reset (read register only)
//   wr_en    write enable
//   wr_addr  write address
//   wr_data  write word
//   rd_addr  read address
//   rd_data  registered read word, one cycle after rd_addr
// ---------------------------------------------------------------------------
module capture_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int WIDTH  = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register clears on reset so software sees zero until first read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/scope_capture.sv
// ---------------------------------------------------------------------------
// scope_capture
// Triggered two-channel sample capture. Samples signal/modulation on each
// sample_en strobe, waits for a level crossing (or auto-trigger timeout),
// then stores DEPTH sample pairs starting with the trigger sample at
// address 0. Software arms, polls done and reads the record back.
//   clk            system clock
//   rst_n          synchronous active-low reset
//   sample_en      one-cycle sample strobe
//   signal_in      selected signal channel
//   modulation_in  selected modulation channel
//   bus            software bus (arm, trigger setup, read port, status)
// ---------------------------------------------------------------------------
module scope_capture
    import scope_pkg::*;
#(
    parameter int DEPTH        = 256,
    parameter int ADDR_W       = 8,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_en,
    input  logic [SAMPLE_W-1:0] signal_in,
    input  logic [SAMPLE_W-1:0] modulation_in,
    scope_capture_if.slave      bus
);

    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_ARMED   = ST_ARMED;
    localparam logic [1:0] S_CAPTURE = ST_CAPTURE;
    localparam logic [1:0] S_DONE    = ST_DONE;

    localparam int                TO_W     = (AUTO_TIMEOUT > 0) ? $clog2(AUTO_TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0]   TO_LIMIT = TO_W'(AUTO_TIMEOUT);
    localparam logic [TO_W-1:0]   TO_MAX   = '1;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    logic [1:0]          state;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [SAMPLE_W-1:0] prev;
    logic                prev_valid;
    logic [TO_W-1:0]     to_count;
    logic                auto_trig_q;

    logic                edge_hit;
    logic                timeout_hit;
    logic                trig_fire;
    logic                cap_write;
    logic                last_write;
    logic                ram_wr_en;
    logic [ADDR_W-1:0]   ram_wr_addr;
    logic [2*SAMPLE_W-1:0] ram_rd_data;

    // Trigger decision for the current strobe. The timeout fires on the strobe
    // after AUTO_TIMEOUT non-triggering strobes; a genuine edge on that same
    // strobe takes precedence so auto_trig only flags forced records.
    always_comb begin
        edge_hit    = trig_edge(bus.trig_mode, prev_valid, prev, signal_in, bus.trig_level);
        timeout_hit = (AUTO_TIMEOUT != 0) && (to_count >= TO_LIMIT);
        trig_fire   = (state == S_ARMED) && sample_en && (edge_hit || timeout_hit);
        cap_write   = (state == S_CAPTURE) && sample_en;
        last_write  = cap_write && (wr_ptr == LAST_PTR);
        // Writes are blocked in the reset cycle so an abort leaves no trace.
        ram_wr_en   = rst_n && (trig_fire || cap_write);
        ram_wr_addr = (state == S_ARMED) ? '0 : wr_ptr;
    end

    // Capture FSM. Arming from IDLE or DONE restarts the record; arm while
    // ARMED/CAPTURE is ignored, and a strobe coinciding with arm is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            prev        <= '0;
            prev_valid  <= 1'b0;
            to_count    <= '0;
            auto_trig_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (state == S_IDLE || bus.arm) begin
                        prev_valid  <= 1'b0;
                        to_count    <= '0;
                        auto_trig_q <= 1'b0;
                        wr_ptr      <= '0;
                    end
                    if (bus.arm) begin
                        state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (sample_en) begin
                        if (trig_fire) begin
                            wr_ptr      <= ADDR_W'(1);
                            auto_trig_q <= !edge_hit;
                            state       <= S_CAPTURE;
                        end else begin
                            prev       <= signal_in;
                            prev_valid <= 1'b1;
                            if (to_count != TO_MAX) begin
                                to_count <= to_count + 1'b1;
                            end
                        end
                    end
                end
                S_CAPTURE: begin
                    if (cap_write) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (last_write) begin
                            state <= S_DONE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    capture_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (2 * SAMPLE_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (ram_wr_en),
        .wr_addr (ram_wr_addr),
        .wr_data ({signal_in, modulation_in}),
        .rd_addr (bus.rd_addr),
        .rd_data (ram_rd_data)
    );

    assign bus.rd_signal     = ram_rd_data[2*SAMPLE_W-1:SAMPLE_W];
    assign bus.rd_modulation = ram_rd_data[SAMPLE_W-1:0];
    assign bus.busy          = (state == S_ARMED) || (state == S_CAPTURE);
    assign bus.done          = (state == S_DONE);
    assign bus.auto_trig     = auto_trig_q;

endmodule

// File: tb/tb_scope_capture.sv
// ---------------------------------------------------------------------------
// tb_scope_capture
// Directed self-checking bench for scope_capture (DEPTH 256, auto-trigger
// timeout 16 strobes). Each scenario drives a hand-built sample sequence and
// compares the read-back record against values computed here.
// ---------------------------------------------------------------------------
module tb_scope_capture;
    import scope_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_en;
    logic [11:0] signal_in;
    logic [11:0] modulation_in;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] rs;
    logic [11:0] rm;
    int          bad;
    logic [11:0] exp_sig [256];
    logic [11:0] exp_mod [256];

    scope_capture_if #(.ADDR_W(8)) bus ();

    scope_capture #(
        .DEPTH        (256),
        .ADDR_W       (8),
        .AUTO_TIMEOUT (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_en     (sample_en),
        .signal_in     (signal_in),
        .modulation_in (modulation_in),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    // Advance one cycle and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One strobe, then gap-1 idle cycles.
    task automatic apply_stimulus(input logic [11:0] sig, input logic [11:0] mod, input int gap);
        signal_in     = sig;
        modulation_in = mod;
        sample_en     = 1'b1;
        tick();
        sample_en = 1'b0;
        for (int g = 1; g < gap; g++) tick();
    endtask

    task automatic pulse_arm();
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
    endtask

    task automatic read_entry(input logic [7:0] addr, output logic [11:0] s, output logic [11:0] m);
        bus.rd_addr = addr;
        tick();
        s = bus.rd_signal;
        m = bus.rd_modulation;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!bus.done && n < 50) begin
            tick();
            n++;
        end
        check_output(tag, 32'(bus.done), 32'd1);
    endtask

    initial begin
        rst_n          = 1'b0;
        sample_en      = 1'b0;
        signal_in      = '0;
        modulation_in  = '0;
        bus.arm        = 1'b0;
        bus.trig_level = 12'h800;
        bus.trig_mode  = TRIG_RISE;
        bus.rd_addr    = '0;

        // Reset state
        repeat (3) tick();
        check_output("rst_busy", 32'(bus.busy), 32'd0);
        check_output("rst_done", 32'(bus.done), 32'd0);
        check_output("rst_auto", 32'(bus.auto_trig), 32'd0);
        check_output("rst_rd_sig", 32'(bus.rd_signal), 32'h000);
        check_output("rst_rd_mod", 32'(bus.rd_modulation), 32'h000);
        rst_n = 1'b1;
        tick();

        // Rising trigger at level 0x800 on an up-ramp; 0x800 is strobe 8
        $display("[TB] rising ramp");
        pulse_arm();
        check_output("rise_busy_after_arm", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 264; i++) begin
            apply_stimulus(12'(12'h780 + 16 * i), 12'(3 * i), 1);
            if (i == 262) check_output("rise_done_early", 32'(bus.done), 32'd0);
        end
        check_output("rise_done", 32'(bus.done), 32'd1);
        check_output("rise_busy_low", 32'(bus.busy), 32'd0);
        check_output("rise_auto", 32'(bus.auto_trig), 32'd0);
        read_entry(8'd0, rs, rm);
        check_output("rise_a0_sig", 32'(rs), 32'h800);
        check_output("rise_a0_mod", 32'(rm), 32'h018);
        read_entry(8'd1, rs, rm);
        check_output("rise_a1_sig", 32'(rs), 32'h810);
        read_entry(8'd255, rs, rm);
        check_output("rise_a255_sig", 32'(rs), 32'h7F0);
        check_output("rise_a255_mod", 32'(rm), 32'h315);

        // Falling trigger; first sample below level must not trigger
        $display("[TB] falling");
        bus.trig_mode  = TRIG_FALL;
        bus.trig_level = 12'h100;
        pulse_arm();
        apply_stimulus(12'h0FF, 12'd0, 1);
        apply_stimulus(12'h100, 12'd1, 1);
        apply_stimulus(12'h100, 12'd2, 1);
        apply_stimulus(12'h100, 12'd3, 1);
        apply_stimulus(12'h0FF, 12'd4, 1);
        for (int k = 1; k < 256; k++) apply_stimulus(12'(12'h200 + k), 12'(4 + k), 1);
        wait_done("fall_done");
        read_entry(8'd0, rs, rm);
        check_output("fall_a0_sig", 32'(rs), 32'h0FF);
        check_output("fall_a0_mod", 32'(rm), 32'h004);
        read_entry(8'd1, rs, rm);
        check_output("fall_a1_sig", 32'(rs), 32'h201);

        // Auto-trigger: flat 0x555 never crosses 0x800, fires on strobe 17
        $display("[TB] auto trigger");
        bus.trig_mode  = TRIG_RISE;
        bus.trig_level = 12'h800;
        pulse_arm();
        for (int i = 0; i < 272; i++) apply_stimulus(12'h555, 12'(i), 1);
        wait_done("auto_done");
        check_output("auto_flag", 32'(bus.auto_trig), 32'd1);
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            read_entry(8'(k), rs, rm);
            if (rs !== 12'h555) bad++;
            if (k == 0) check_output("auto_a0_mod", 32'(rm), 32'h010);
            if (k == 255) check_output("auto_a255_mod", 32'(rm), 32'h10F);
        end
        check_output("auto_flat_bad", 32'(bad), 32'd0);

        // Free-run; strobe in the arm cycle is dropped, mid-capture arms ignored
        $display("[TB] free run");
        bus.trig_mode = TRIG_FREE;
        signal_in     = 12'hABC;
        modulation_in = 12'hABC;
        sample_en     = 1'b1;
        bus.arm       = 1'b1;
        tick();
        sample_en = 1'b0;
        bus.arm   = 1'b0;
        check_output("free_busy", 32'(bus.busy), 32'd1);
        for (int k = 0; k < 256; k++) begin
            bus.arm = (k == 50 || k == 150);
            apply_stimulus(12'h300, 12'(k), 1);
            bus.arm = 1'b0;
        end
        wait_done("free_done");
        check_output("free_auto_cleared", 32'(bus.auto_trig), 32'd0);
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            read_entry(8'(k), rs, rm);
            if (rm !== 12'(k)) bad++;
            if (k == 0) check_output("free_a0_mod", 32'(rm), 32'h000);
        end
        check_output("free_linear_bad", 32'(bad), 32'd0);

        // Reset at wr_ptr 100, then a fresh record
        $display("[TB] reset mid capture");
        pulse_arm();
        for (int k = 0; k < 100; k++) apply_stimulus(12'h111, 12'(12'h400 + k), 1);
        check_output("abort_busy_before", 32'(bus.busy), 32'd1);
        rst_n         = 1'b0;
        sample_en     = 1'b1;
        modulation_in = 12'hEEE;
        tick();
        rst_n     = 1'b1;
        sample_en = 1'b0;
        check_output("abort_busy", 32'(bus.busy), 32'd0);
        check_output("abort_done", 32'(bus.done), 32'd0);
        read_entry(8'd100, rs, rm);
        check_output("abort_a100_old", 32'(rm), 32'h064);
        read_entry(8'd99, rs, rm);
        check_output("abort_a99_new", 32'(rm), 32'h463);
        pulse_arm();
        for (int k = 0; k < 256; k++) apply_stimulus(12'h222, 12'(12'h800 + k), 1);
        wait_done("rearm_done");
        read_entry(8'd0, rs, rm);
        check_output("rearm_a0_mod", 32'(rm), 32'h800);
        read_entry(8'd100, rs, rm);
        check_output("rearm_a100_mod", 32'(rm), 32'h864);
        read_entry(8'd255, rs, rm);
        check_output("rearm_a255_mod", 32'(rm), 32'h8FF);

        // Irregular strobe spacing (1, 3, 7) against a dense reference record
        $display("[TB] irregular strobes");
        for (int k = 0; k < 256; k++) begin
            exp_sig[k] = 12'(k * 37);
            exp_mod[k] = 12'(k * 91 + 5);
        end
        pulse_arm();
        for (int k = 0; k < 256; k++) begin
            apply_stimulus(12'(k * 37), 12'(k * 91 + 5), (k % 3 == 0) ? 1 : ((k % 3 == 1) ? 3 : 7));
        end
        wait_done("irr_done");
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            read_entry(8'(k), rs, rm);
            if (rs !== exp_sig[k] || rm !== exp_mod[k]) bad++;
        end
        check_output("irr_record_bad", 32'(bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scope_capture.md
# scope_capture

Triggered sample-capture stage directly downstream of the signal/modulation selection mux. It samples the selected 12-bit signal and modulation channels on a sample-rate strobe, waits for a level-crossing trigger (or an auto-trigger timeout), stores a fixed-length record of both channels in an internal dual-channel buffer, and exposes that record to the Nios II over a simple registered read port. Software arms a capture, polls `done`, then reads the buffer out.

## Interface
- `DEPTH`, 256: samples per record; power of two.
- `ADDR_W`, 8: log2(DEPTH).
- `AUTO_TIMEOUT`, 4096: sample strobes in ARMED without a trigger before a forced trigger; 0 disables auto-trigger.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `sample_en`  in  1  one-cycle sample strobe; inputs are sampled only when high.
- `signal_in`  in  12  selected signal (unsigned, mid-scale 12'h800).
- `modulation_in`  in  12  selected modulation (unsigned).
- `trig_level`  in  12  trigger threshold; must be held stable while not IDLE/DONE.
- `trig_mode`  in  2  00 rising, 01 falling, 10 free-run (immediate), 11 treated as rising.
- `arm`  in  1  one-cycle pulse from software to start a capture.
- `rd_addr`  in  ADDR_W  read address, 0 = trigger sample.
- `rd_signal`  out  12  buffered signal at `rd_addr`, registered.
- `rd_modulation`  out  12  buffered modulation at `rd_addr`, registered.
- `busy`  out  1  high in ARMED or CAPTURE.
- `done`  out  1  high in DONE.
- `auto_trig`  out  1  record was started by timeout, valid while `done`.

## Operation
- States: IDLE, ARMED, CAPTURE, DONE.
- IDLE: `arm` -> ARMED. Clear `prev_valid`, timeout counter, `auto_trig`.
- ARMED, on `sample_en`:
  - Trigger is true if any of:
    - rising: `prev_valid` && prev < `trig_level` && `signal_in` >= `trig_level`;
    - falling: `prev_valid` && prev >= level && cur < level;
    - free-run: always true.
  - First strobe after arming only loads prev and sets `prev_valid`; it cannot trigger except in free-run.
  - On trigger: write the current sample pair to address 0, set wr_ptr = 1, go to CAPTURE.
  - Otherwise increment the timeout counter. When it reaches `AUTO_TIMEOUT`, that strobe's sample triggers and sets `auto_trig`.
- CAPTURE, on `sample_en`: write the pair at wr_ptr and increment. The write at wr_ptr = DEPTH-1 goes to DONE. No wrap; exactly DEPTH samples are stored.
- DONE: hold the buffer. `arm` -> ARMED (new capture overwrites).
- `arm` while ARMED or CAPTURE is ignored.
- Comparisons are unsigned 12-bit. The timeout counter is wide enough for `AUTO_TIMEOUT` and saturates.
- Reads are allowed in any state. Reading during CAPTURE returns whatever is stored; no coherence is guaranteed.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `auto_trig` 0, `rd_signal`/`rd_modulation` 12'h000, wr_ptr 0, `prev_valid` 0. Buffer contents are undefined.
- `arm` high in cycle n -> `busy` high in n+1.
- Trigger strobe in cycle n -> address 0 written at the edge ending cycle n.
- Last write in cycle n -> `done` high and `busy` low in n+1.
- Read latency is 1 cycle: `rd_addr` in cycle n -> data valid in n+1.
- Read and write of the same address in one cycle returns old data.
- `sample_en` and `arm` in the same cycle while in IDLE/DONE: the arm is taken; that strobe is not sampled.
- `rst_n` low mid-capture -> IDLE on the next edge. No further writes occur.

## Structure
- Package `scope_pkg`:
  - state enum `cap_state_t`;
  - `trig_mode` encodings `TRIG_RISE`, `TRIG_FALL`, `TRIG_FREE`;
  - `SAMPLE_W` = 12.
- Sub-module `capture_ram`: simple dual-port, 24-bit wide × DEPTH (signal in upper 12 bits, modulation in lower 12), one write port, one registered read port. Inferable as block RAM.
- Trigger detect, FSM and counters are in `scope_capture`.

## Test plan
- Rising trigger, level 12'h800, mode 00, ramp 12'h700 -> 12'h900 step 0x10 per strobe after `arm` -> `rd_addr`=0 returns 12'h800, addr 1 returns 12'h810. `done` rises one cycle after the 256th post-trigger strobe; `auto_trig` = 0.
- Falling mode, constant 12'h100 then drop to 12'h0FF, level 12'h100 -> trigger on the 12'h0FF sample. A first-sample-below-level after arm does not trigger.
- No crossing, `AUTO_TIMEOUT`=16, constant 12'h555 -> trigger on the 17th strobe, `auto_trig` = 1, all 256 entries 12'h555.
- Free-run with modulation ramp 0..255 -> `rd_modulation` at addr k == k for all k. `arm` pulses mid-capture are ignored (record still linear).
- `rst_n` asserted at wr_ptr = 100 -> `busy`/`done` 0 next cycle. Re-`arm` produces a complete fresh record.
- Irregular `sample_en` (every 1, 3, 7 cycles) -> record content identical to a dense-strobe reference model.
